// File: rtl/axi_response_collector.sv
// Return-path collector for one AXI target port: round-robin merges B and R
// responses from the initiator-side ports and strips the routing ID bits.
//
// state   | meaning
// R_IDLE  | no R burst in flight; round-robin pick from r_ptr
// R_BURST | grant held on r_sel until the last beat handshakes
module axi_response_collector #(
  parameter int AXI_DATA_W  = 64,
  parameter int AXI_USER_W  = 6,
  parameter int N_INIT_PORT = 5,
  parameter int N_TARG_PORT = 8,
  parameter int AXI_ID_IN   = 16,
  parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
  parameter int AXI_ID_OUT  = AXI_ID_IN + LOG_N_TARG,
  parameter int LOG_N_INIT  = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_INIT_PORT*AXI_ID_OUT-1:0] bid_i,
  input  logic [N_INIT_PORT*2-1:0]          bresp_i,
  input  logic [N_INIT_PORT*AXI_USER_W-1:0] buser_i,
  input  logic [N_INIT_PORT-1:0]            bvalid_i,
  output logic [N_INIT_PORT-1:0]            bready_o,
  input  logic [N_INIT_PORT*AXI_ID_OUT-1:0] rid_i,
  input  logic [N_INIT_PORT*AXI_DATA_W-1:0] rdata_i,
  input  logic [N_INIT_PORT*2-1:0]          rresp_i,
  input  logic [N_INIT_PORT-1:0]            rlast_i,
  input  logic [N_INIT_PORT*AXI_USER_W-1:0] ruser_i,
  input  logic [N_INIT_PORT-1:0]            rvalid_i,
  output logic [N_INIT_PORT-1:0]            rready_o,
  output logic [AXI_ID_IN-1:0]              bid_o,
  output logic [1:0]                        bresp_o,
  output logic [AXI_USER_W-1:0]             buser_o,
  output logic                              bvalid_o,
  input  logic                              bready_i,
  output logic [AXI_ID_IN-1:0]              rid_o,
  output logic [AXI_DATA_W-1:0]             rdata_o,
  output logic [1:0]                        rresp_o,
  output logic                              rlast_o,
  output logic [AXI_USER_W-1:0]             ruser_o,
  output logic                              rvalid_o,
  input  logic                              rready_i
);

  typedef enum logic {R_IDLE, R_BURST} r_state_t;

  logic [AXI_ID_IN-1:0]  bid_a   [N_INIT_PORT];
  logic [1:0]            bresp_a [N_INIT_PORT];
  logic [AXI_USER_W-1:0] buser_a [N_INIT_PORT];
  logic [AXI_ID_IN-1:0]  rid_a   [N_INIT_PORT];
  logic [AXI_DATA_W-1:0] rdata_a [N_INIT_PORT];
  logic [1:0]            rresp_a [N_INIT_PORT];
  logic [AXI_USER_W-1:0] ruser_a [N_INIT_PORT];
  logic [N_INIT_PORT*2*(AXI_ID_OUT-AXI_ID_IN)-1:0] route_bits;
  logic                  unused_route_bits;

  genvar g;
  generate
    for (g = 0; g < N_INIT_PORT; g++) begin : g_unpack
      assign bid_a[g]   = bid_i[g*AXI_ID_OUT +: AXI_ID_IN];
      assign bresp_a[g] = bresp_i[g*2 +: 2];
      assign buser_a[g] = buser_i[g*AXI_USER_W +: AXI_USER_W];
      assign rid_a[g]   = rid_i[g*AXI_ID_OUT +: AXI_ID_IN];
      assign rdata_a[g] = rdata_i[g*AXI_DATA_W +: AXI_DATA_W];
      assign rresp_a[g] = rresp_i[g*2 +: 2];
      assign ruser_a[g] = ruser_i[g*AXI_USER_W +: AXI_USER_W];
      // routing bits are dropped on the way back to the target
      assign route_bits[g*2*(AXI_ID_OUT-AXI_ID_IN) +: 2*(AXI_ID_OUT-AXI_ID_IN)] =
        {bid_i[g*AXI_ID_OUT+AXI_ID_IN +: AXI_ID_OUT-AXI_ID_IN],
         rid_i[g*AXI_ID_OUT+AXI_ID_IN +: AXI_ID_OUT-AXI_ID_IN]};
    end
  endgenerate

  assign unused_route_bits = ^route_bits;

  function automatic logic [LOG_N_INIT-1:0] rr_pick(
    input logic [N_INIT_PORT-1:0] req,
    input logic [LOG_N_INIT-1:0]  ptr
  );
    logic [LOG_N_INIT-1:0] pick;
    logic                  found;
    int                    j;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_INIT_PORT; i++) begin
      j = int'(ptr) + i;
      if (j >= N_INIT_PORT) j = j - N_INIT_PORT;
      if (!found && req[j]) begin
        pick  = LOG_N_INIT'(j);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [LOG_N_INIT-1:0] next_idx(input logic [LOG_N_INIT-1:0] x);
    if (int'(x) >= N_INIT_PORT - 1) return '0;
    return x + LOG_N_INIT'(1);
  endfunction

  logic [LOG_N_INIT-1:0] b_ptr, b_sel, b_win;
  logic                  b_lock, b_vld;
  logic [LOG_N_INIT-1:0] r_ptr, r_sel, r_win;
  logic                  r_vld, r_last;
  r_state_t              r_state;

  // reset gates the valids so nothing leaks out while rst_n is low
  always_comb begin
    b_win  = b_lock ? b_sel : rr_pick(bvalid_i, b_ptr);
    b_vld  = rst_n & bvalid_i[b_win];
    r_win  = (r_state == R_BURST) ? r_sel : rr_pick(rvalid_i, r_ptr);
    r_vld  = rst_n & rvalid_i[r_win];
    r_last = r_vld & rlast_i[r_win];
  end

  always_comb begin
    bready_o = '0;
    bid_o    = '0;
    bresp_o  = '0;
    buser_o  = '0;
    bvalid_o = b_vld;
    if (b_vld) begin
      bready_o[b_win] = bready_i;
      bid_o           = bid_a[b_win];
      bresp_o         = bresp_a[b_win];
      buser_o         = buser_a[b_win];
    end
  end

  always_comb begin
    rready_o = '0;
    rid_o    = '0;
    rdata_o  = '0;
    rresp_o  = '0;
    ruser_o  = '0;
    rlast_o  = r_last;
    rvalid_o = r_vld;
    if (r_vld) begin
      rready_o[r_win] = rready_i;
      rid_o           = rid_a[r_win];
      rdata_o         = rdata_a[r_win];
      rresp_o         = rresp_a[r_win];
      ruser_o         = ruser_a[r_win];
    end
  end

  // a stalled B response pins the grant so the payload stays stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_ptr  <= '0;
      b_sel  <= '0;
      b_lock <= 1'b0;
    end else if (b_vld) begin
      if (bready_i) begin
        b_lock <= 1'b0;
        b_ptr  <= next_idx(b_win);
      end else begin
        b_lock <= 1'b1;
        b_sel  <= b_win;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (r_vld) begin
            if (rready_i && r_last) begin
              r_ptr <= next_idx(r_win);
            end else begin
              r_state <= R_BURST;
              r_sel   <= r_win;
            end
          end
        end
        R_BURST: begin
          if (r_vld && rready_i && r_last) begin
            r_state <= R_IDLE;
            r_ptr   <= next_idx(r_sel);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_response_collector.sv
// Directed bench for axi_response_collector: B round-robin, B stall lock,
// R burst lock, simultaneous B/R and mid-burst asynchronous reset.
module tb_axi_response_collector;
  localparam int N   = 5;
  localparam int IDO = 19;
  localparam int IDI = 16;
  localparam int DW  = 64;
  localparam int UW  = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*IDO-1:0] bid_i, rid_i;
  logic [N*2-1:0]   bresp_i, rresp_i;
  logic [N*UW-1:0]  buser_i, ruser_i;
  logic [N*DW-1:0]  rdata_i;
  logic [N-1:0]     bvalid_i, rvalid_i, rlast_i, bready_o, rready_o;
  logic [IDI-1:0]   bid_o, rid_o;
  logic [1:0]       bresp_o, rresp_o;
  logic [UW-1:0]    buser_o, ruser_o;
  logic [DW-1:0]    rdata_o;
  logic             bvalid_o, bready_i, rlast_o, rvalid_o, rready_i;

  logic [IDO-1:0] bid_a [N];
  logic [1:0]     bresp_a [N];
  logic [UW-1:0]  buser_a [N];
  logic [IDO-1:0] rid_a [N];
  logic [DW-1:0]  rdata_a [N];
  logic [1:0]     rresp_a [N];
  logic [UW-1:0]  ruser_a [N];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    bid_i = '0; bresp_i = '0; buser_i = '0;
    rid_i = '0; rdata_i = '0; rresp_i = '0; ruser_i = '0;
    for (int k = 0; k < N; k++) begin
      bid_i[k*IDO +: IDO] = bid_a[k];
      bresp_i[k*2 +: 2]   = bresp_a[k];
      buser_i[k*UW +: UW] = buser_a[k];
      rid_i[k*IDO +: IDO] = rid_a[k];
      rdata_i[k*DW +: DW] = rdata_a[k];
      rresp_i[k*2 +: 2]   = rresp_a[k];
      ruser_i[k*UW +: UW] = ruser_a[k];
    end
  end

  axi_response_collector #(
    .AXI_DATA_W(DW), .AXI_USER_W(UW), .N_INIT_PORT(N), .N_TARG_PORT(8), .AXI_ID_IN(IDI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .bid_i(bid_i), .bresp_i(bresp_i), .buser_i(buser_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i), .ruser_i(ruser_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .buser_o(buser_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .ruser_o(ruser_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i)
  );

  task automatic init_payload();
    for (int k = 0; k < N; k++) begin
      bid_a[k]   = {3'(7 - k), 16'hB000 | 16'(k)};
      bresp_a[k] = 2'(k);
      buser_a[k] = 6'(k + 8);
      rid_a[k]   = {3'(k + 1), 16'hC000 | 16'(k)};
      rdata_a[k] = 64'hDA7A_0000_0000_0000 | 64'(k);
      rresp_a[k] = 2'(3 - k);
      ruser_a[k] = 6'(k + 32);
    end
    bid_a[0] = 19'h5_1234;
  endtask

  task automatic clear_inputs();
    bvalid_i = '0; rvalid_i = '0; rlast_i = '0; bready_i = 1'b0; rready_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bvalid_i = '1; rvalid_i = '1; rlast_i = '1; bready_i = 1'b1; rready_i = 1'b1;
    @(negedge clk); #1;
    n_chk++; if (bready_o !== 5'b0) begin n_fail++; $display("FAIL reset_bready got %b expected %b", bready_o, 5'b0); end
    n_chk++; if (rready_o !== 5'b0) begin n_fail++; $display("FAIL reset_rready got %b expected %b", rready_o, 5'b0); end
    n_chk++; if (bvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid got %b expected 0", bvalid_o); end
    n_chk++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b expected 0", rvalid_o); end
    n_chk++; if (bid_o !== 16'h0) begin n_fail++; $display("FAIL reset_bid got %h expected 0", bid_o); end
    n_chk++; if (rdata_o !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got %h expected 0", rdata_o); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (bready_o !== 5'b00001) begin n_fail++; $display("FAIL release_bready got %b expected %b", bready_o, 5'b00001); end
    n_chk++; if (rready_o !== 5'b00001) begin n_fail++; $display("FAIL release_rready got %b expected %b", rready_o, 5'b00001); end
    n_chk++; if (bid_o !== 16'h1234) begin n_fail++; $display("FAIL release_bid got %h expected %h", bid_o, 16'h1234); end
    n_chk++; if (rid_o !== 16'hC000) begin n_fail++; $display("FAIL release_rid got %h expected %h", rid_o, 16'hC000); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_b_round_robin();
    int exp_g [4] = '{0, 2, 4, 0};
    logic [15:0] exp_id;
    do_reset();
    bvalid_i = 5'b10101;
    bready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_id = (exp_g[i] == 0) ? 16'h1234 : (16'hB000 | 16'(exp_g[i]));
      n_chk++; if (bready_o !== 5'(1 << exp_g[i])) begin n_fail++; $display("FAIL b_rr_ready beat %0d got %b expected %b", i, bready_o, 5'(1 << exp_g[i])); end
      n_chk++; if (bid_o !== exp_id) begin n_fail++; $display("FAIL b_rr_id beat %0d got %h expected %h", i, bid_o, exp_id); end
      n_chk++; if (bresp_o !== 2'(exp_g[i])) begin n_fail++; $display("FAIL b_rr_resp beat %0d got %0d expected %0d", i, bresp_o, exp_g[i]); end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_b_stall();
    do_reset();
    bvalid_i = 5'b01000;
    bready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) bvalid_i[1] = 1'b1;
      #1;
      n_chk++; if (bvalid_o !== 1'b1) begin n_fail++; $display("FAIL b_stall_valid cycle %0d got %b expected 1", i, bvalid_o); end
      n_chk++; if (bready_o !== 5'b0) begin n_fail++; $display("FAIL b_stall_ready cycle %0d got %b expected %b", i, bready_o, 5'b0); end
      n_chk++; if (bid_o !== 16'hB003) begin n_fail++; $display("FAIL b_stall_id cycle %0d got %h expected %h", i, bid_o, 16'hB003); end
      n_chk++; if (buser_o !== 6'd11) begin n_fail++; $display("FAIL b_stall_user cycle %0d got %0d expected 11", i, buser_o); end
      @(negedge clk);
    end
    bready_i = 1'b1;
    #1;
    n_chk++; if (bready_o !== 5'b01000) begin n_fail++; $display("FAIL b_stall_hs got %b expected %b", bready_o, 5'b01000); end
    @(negedge clk);
    bvalid_i = 5'b00010;
    #1;
    n_chk++; if (bready_o !== 5'b00010) begin n_fail++; $display("FAIL b_stall_next got %b expected %b", bready_o, 5'b00010); end
    n_chk++; if (bid_o !== 16'hB001) begin n_fail++; $display("FAIL b_stall_next_id got %h expected %h", bid_o, 16'hB001); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_r_burst();
    // per cycle: src2 valid, src0 valid, src2 last, rready_i, expected source (-1 none), src2 beat
    bit          v2  [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 0};
    bit          v0  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    bit          l2  [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    bit          rdy [9] = '{0, 1, 0, 1, 1, 1, 0, 1, 1};
    int          src [9] = '{2, 2, 2, 2, -1, 2, 2, 2, 0};
    int          bt  [9] = '{0, 0, 1, 1, 0, 2, 3, 3, 0};
    logic [4:0]  exp_rr;
    logic [63:0] exp_d;
    logic        exp_l;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      rvalid_i    = '0;
      rvalid_i[2] = v2[c];
      rvalid_i[0] = v0[c];
      rlast_i     = '0;
      rlast_i[2]  = l2[c];
      rlast_i[0]  = 1'b1;
      rready_i    = rdy[c];
      rdata_a[2]  = 64'hB0B0_0000_0000_0000 | 64'(bt[c]);
      #1;
      exp_rr = '0;
      exp_d  = '0;
      exp_l  = 1'b0;
      if (src[c] == 2) begin
        exp_rr[2] = rdy[c];
        exp_d     = 64'hB0B0_0000_0000_0000 | 64'(bt[c]);
        exp_l     = l2[c];
      end else if (src[c] == 0) begin
        exp_rr[0] = rdy[c];
        exp_d     = 64'hDA7A_0000_0000_0000;
        exp_l     = 1'b1;
      end
      n_chk++; if (rvalid_o !== (src[c] >= 0)) begin n_fail++; $display("FAIL r_burst_valid cycle %0d got %b expected %b", c, rvalid_o, src[c] >= 0); end
      n_chk++; if (rready_o !== exp_rr) begin n_fail++; $display("FAIL r_burst_ready cycle %0d got %b expected %b", c, rready_o, exp_rr); end
      n_chk++; if (rdata_o !== exp_d) begin n_fail++; $display("FAIL r_burst_data cycle %0d got %h expected %h", c, rdata_o, exp_d); end
      n_chk++; if (rlast_o !== exp_l) begin n_fail++; $display("FAIL r_burst_last cycle %0d got %b expected %b", c, rlast_o, exp_l); end
      @(negedge clk);
    end
    rdata_a[2] = 64'hDA7A_0000_0000_0002;
    clear_inputs();
  endtask

  task automatic test_simultaneous();
    do_reset();
    rvalid_i = 5'b00010; rlast_i = '1; rready_i = 1'b1;
    #1;
    n_chk++; if (rready_o !== 5'b00010) begin n_fail++; $display("FAIL sim_pre_rready got %b expected %b", rready_o, 5'b00010); end
    @(negedge clk);
    bvalid_i = 5'b00010; rvalid_i = 5'b10000; bready_i = 1'b1;
    #1;
    n_chk++; if (bready_o !== 5'b00010) begin n_fail++; $display("FAIL sim_bready got %b expected %b", bready_o, 5'b00010); end
    n_chk++; if (rready_o !== 5'b10000) begin n_fail++; $display("FAIL sim_rready got %b expected %b", rready_o, 5'b10000); end
    n_chk++; if (bid_o !== 16'hB001) begin n_fail++; $display("FAIL sim_bid got %h expected %h", bid_o, 16'hB001); end
    n_chk++; if (rid_o !== 16'hC004) begin n_fail++; $display("FAIL sim_rid got %h expected %h", rid_o, 16'hC004); end
    n_chk++; if (ruser_o !== 6'd36) begin n_fail++; $display("FAIL sim_ruser got %0d expected 36", ruser_o); end
    @(negedge clk);
    bvalid_i = '1; rvalid_i = '1; bready_i = 1'b0; rready_i = 1'b0;
    #1;
    n_chk++; if (bid_o !== 16'hB002) begin n_fail++; $display("FAIL sim_bptr_next got %h expected %h", bid_o, 16'hB002); end
    n_chk++; if (rid_o !== 16'hC000) begin n_fail++; $display("FAIL sim_rptr_wrap got %h expected %h", rid_o, 16'hC000); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_mid_burst_reset();
    do_reset();
    rvalid_i = 5'b00100; rlast_i = 5'b00100; rready_i = 1'b1;
    #1;
    n_chk++; if (rready_o !== 5'b00100) begin n_fail++; $display("FAIL mrst_single got %b expected %b", rready_o, 5'b00100); end
    @(negedge clk);
    rvalid_i = 5'b01000; rlast_i = '0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_chk++; if (rready_o !== 5'b01000) begin n_fail++; $display("FAIL mrst_beat %0d got %b expected %b", i, rready_o, 5'b01000); end
      @(negedge clk);
    end
    rvalid_i = 5'b01010;
    #1;
    n_chk++; if (rready_o !== 5'b01000) begin n_fail++; $display("FAIL mrst_locked got %b expected %b", rready_o, 5'b01000); end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL mrst_rvalid got %b expected 0", rvalid_o); end
    n_chk++; if (rready_o !== 5'b0) begin n_fail++; $display("FAIL mrst_rready got %b expected %b", rready_o, 5'b0); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (rready_o !== 5'b00010) begin n_fail++; $display("FAIL mrst_after_ready got %b expected %b", rready_o, 5'b00010); end
    n_chk++; if (rid_o !== 16'hC001) begin n_fail++; $display("FAIL mrst_after_rid got %h expected %h", rid_o, 16'hC001); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    init_payload();
    test_reset();
    test_b_round_robin();
    test_b_stall();
    test_r_burst();
    test_simultaneous();
    test_mid_burst_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
